mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous SRAM among NUM_REQ core-side requesters: port 0 program loader, 1 data memory, 2 instruction fetch.
//  Round-robin arbitration with an optional lock for multi-beat atomic sequences.
//  Losing requesters see gnt low and must stall; the core's stall logic consumes ~gnt.
// PARAMETERS
//  NUM_REQ       3   number of requester ports (1..8)
//  DATA_WIDTH   32   data bus width
//  ADDRESS_BITS 20   word-address width
// PORTS
//  clock      in   1                     core clock
//  reset      in   1                     asynchronous, active-high
//  req        in   NUM_REQ               request per port, level, held until granted
//  we         in   NUM_REQ               1=write, 0=read
//  lock       in   NUM_REQ               keep grant after this access
//  addr       in   NUM_REQ*ADDRESS_BITS  packed, port i at [i*ADDRESS_BITS +: ADDRESS_BITS]
//  wdata      in   NUM_REQ*DATA_WIDTH    packed write data
//  gnt        out  NUM_REQ               one-hot/zero, access accepted this cycle
//  rvalid     out  NUM_REQ               read data valid for port i
//  rdata      out  DATA_WIDTH            read data, shared, qualified by rvalid
//  mem_en     out  1                     SRAM enable
//  mem_we     out  1                     SRAM write enable
//  mem_addr   out  ADDRESS_BITS          SRAM address
//  mem_wdata  out  DATA_WIDTH            SRAM write data
//  mem_rdata  in   DATA_WIDTH            SRAM read data, 1 cycle after mem_en&~mem_we
//  perf_clear in   1                     clear perf counters (MEM_ARB_PERF_EN)
//  perf_grants   out 32                  granted accesses
//  perf_conflict out 32                  requester-cycles with req & ~gnt
// BEHAVIOUR
//  - gnt is combinational from req and registered state; zero-latency accept. mem_* driven combinationally from the granted port.
//  - State ARB: grant the first requester at or after rr_ptr, wrapping mod NUM_REQ. After a grant, rr_ptr <= winner+1, wrapping NUM_REQ-1 -> 0.
//  - ARB -> LOCKED when the winner has lock=1; lock_owner <= winner.
//  - LOCKED: only lock_owner may be granted, even with other reqs pending. Other ports' gnt = 0.
//  - LOCKED -> ARB on a granted owner access with lock=0, or an owner cycle with req=0 (abandoned lock). rr_ptr <= owner+1.
//  - Reads: rvalid[i] is registered, high the cycle after the grant, rdata = mem_rdata. Back-to-back reads give rvalid every cycle.
//  - Writes: done in the grant cycle; no rvalid.
//  - No request, or LOCKED with owner idle: mem_en=0, mem_we=0, mem_addr/mem_wdata=0.
//  - Reset (async): state=ARB, rr_ptr=0, lock_owner=0, rvalid=0, counters=0. mem_en/mem_we/gnt forced 0 while reset is high.
//  - Reset during an outstanding read: its rvalid is dropped, never replayed.
//  - NUM_REQ=1: gnt = req, lock has no effect on ordering.
// CONFIGURATION
//  MEM_ARB_PERF_EN defined:
//   - perf_grants += 1 per granted access.
//   - perf_conflict += popcount(req & ~gnt) per cycle.
//   - Both 32-bit, saturate at 32'hFFFFFFFF.
//   - perf_clear zeroes both next edge and wins over increments in the same cycle.
//  MEM_ARB_PERF_EN undefined: counter logic is absent; perf_* are tied 32'd0 and perf_clear is ignored.
// STRUCTURE
//  Package mem_arb_pkg:
//   - state encoding ARB_S=1'b0, LOCKED_S=1'b1.
//   - PERF_W=32, PERF_MAX.
//   - NOP constant for idle memory command.
//  Sub-module rr_picker (NUM_REQ):
//   - combinational inputs req and rr_ptr; outputs one-hot grant and winner index.
//   - The arbiter adds state, lock, read return pipe and counters.
// TESTING
//  1 Reset: reset=1 with req=3'b111 -> gnt=0, mem_en=0, rvalid=0. Deassert -> port 0 granted first.
//  2 Round-robin: req=3'b111 held for 6 cycles -> gnt 001,010,100,001,010,100. perf_conflict=12 (PERF_EN).
//  3 Read return: port 2 reads addr 0x00010 where SRAM holds 0x00000013 -> rvalid=3'b100, rdata=0x00000013 next cycle.
//  4 Lock: port 1 lock=1 for 3 writes (0x100..0x102), port 2 req high throughout -> port 2 gnt=0 for 3 cycles, granted on 4th.
//  5 Abandoned lock: port 0 locks then drops req, ports 1,2 requesting -> next cycle ARB, port 1 granted.
//  6 Async reset during read: port 1 read granted, reset pulse before next edge -> rvalid stays 0, rr_ptr=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and constants for the memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [0:0] {
    ARB_S    = 1'b0,
    LOCKED_S = 1'b1
  } arb_state_t;

  localparam int                PERF_W   = 32;
  localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

  typedef struct packed {
    logic en;
    logic we;
  } mem_ctl_t;

  localparam mem_ctl_t NOP = '{en: 1'b0, we: 1'b0};

  // Saturating accumulate; the increment is at most one popcount of 8 requesters.
  function automatic logic [PERF_W-1:0] sat_add(input logic [PERF_W-1:0] a,
                                                 input logic [3:0]        b);
    logic [PERF_W:0] sum;
    sum = {1'b0, a} + {{(PERF_W-3){1'b0}}, b};
    return sum[PERF_W] ? PERF_MAX : sum[PERF_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_rr_picker.sv
// ============================================================================
// Module   : rr_picker
// Brief    : Combinational round-robin pick: first requester at or after rr_ptr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   winner
);

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  always_comb begin
    grant   = '0;
    winner  = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(NUM_REQ)) w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
      w_idx = w_sum[PTR_W-1:0];
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        winner       = w_idx;
        w_found      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Round-robin single-port SRAM arbiter with lock for atomic bursts.
//            Optional perf counters enabled by defining MEM_ARB_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              we,
  input  logic [NUM_REQ-1:0]              lock,
  input  logic [NUM_REQ*ADDRESS_BITS-1:0] addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   wdata,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              rvalid,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [ADDRESS_BITS-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  input  logic                            perf_clear,
  output logic [PERF_W-1:0]               perf_grants,
  output logic [PERF_W-1:0]               perf_conflict
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_REQ-1)) ? '0 : p + 1'b1;
  endfunction

  arb_state_t               r_state, w_state_nx;
  logic [PTR_W-1:0]         r_rr_ptr, w_rr_ptr_nx;
  logic [PTR_W-1:0]         r_lock_owner, w_lock_owner_nx;
  logic [NUM_REQ-1:0]       r_rvalid;
  logic [NUM_REQ-1:0]       w_pick_gnt, w_gnt;
  logic [PTR_W-1:0]         w_pick_idx, w_win;
  logic                     w_any;
  mem_ctl_t                 w_ctl;
  logic [ADDRESS_BITS-1:0]  w_addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]    w_wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_addr_arr[gi]  = addr[gi*ADDRESS_BITS +: ADDRESS_BITS];
    assign w_wdata_arr[gi] = wdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_picker (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .grant  (w_pick_gnt),
    .winner (w_pick_idx)
  );

  always_comb begin
    w_gnt           = '0;
    w_win           = w_pick_idx;
    w_state_nx      = r_state;
    w_rr_ptr_nx     = r_rr_ptr;
    w_lock_owner_nx = r_lock_owner;
    // Reset is asynchronous, so the accept path is gated immediately too.
    if (!reset) begin
      case (r_state)
        ARB_S: begin
          w_gnt = w_pick_gnt;
          if (|w_pick_gnt) begin
            w_rr_ptr_nx = ptr_inc(w_pick_idx);
            if (lock[w_pick_idx]) begin
              w_state_nx      = LOCKED_S;
              w_lock_owner_nx = w_pick_idx;
            end
          end
        end
        LOCKED_S: begin
          w_win = r_lock_owner;
          if (req[r_lock_owner]) w_gnt[r_lock_owner] = 1'b1;
          // Release on a final unlocked beat or when the owner walks away.
          if (!req[r_lock_owner] || !lock[r_lock_owner]) begin
            w_state_nx  = ARB_S;
            w_rr_ptr_nx = ptr_inc(r_lock_owner);
          end
        end
        default: w_state_nx = ARB_S;
      endcase
    end
  end

  assign w_any     = |w_gnt;
  assign w_ctl     = w_any ? '{en: 1'b1, we: we[w_win]} : NOP;
  assign gnt       = w_gnt;
  assign mem_en    = w_ctl.en;
  assign mem_we    = w_ctl.we;
  assign mem_addr  = w_any ? w_addr_arr[w_win]  : '0;
  assign mem_wdata = w_any ? w_wdata_arr[w_win] : '0;
  assign rvalid    = r_rvalid;
  assign rdata     = mem_rdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ARB_S;
      r_rr_ptr     <= '0;
      r_lock_owner <= '0;
      r_rvalid     <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_rr_ptr     <= w_rr_ptr_nx;
      r_lock_owner <= w_lock_owner_nx;
      r_rvalid     <= w_gnt & ~we;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [PERF_W-1:0] r_perf_grants, r_perf_conflict;
  logic [3:0]        w_conflicts;

  always_comb begin
    w_conflicts = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_conflicts = w_conflicts + {3'b000, req[i] & ~w_gnt[i]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_perf_grants   <= '0;
      r_perf_conflict <= '0;
    end else if (perf_clear) begin
      r_perf_grants   <= '0;
      r_perf_conflict <= '0;
    end else begin
      r_perf_grants   <= sat_add(r_perf_grants, {3'b000, w_any});
      r_perf_conflict <= sat_add(r_perf_conflict, w_conflicts);
    end
  end

  assign perf_grants   = r_perf_grants;
  assign perf_conflict = r_perf_conflict;
`else
  logic w_unused_perf_clear;
  assign w_unused_perf_clear = perf_clear;
  assign perf_grants         = '0;
  assign perf_conflict       = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed vector-table bench for mem_port_arbiter (3 ports).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clock;
  logic        reset;
  logic [2:0]  req, we, lock, gnt, rvalid;
  logic [59:0] addr;
  logic [95:0] wdata;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic        mem_en, mem_we, perf_clear;
  logic [19:0] mem_addr;
  logic [31:0] perf_grants, perf_conflict;

  int checks   = 0;
  int failures = 0;

  logic [31:0] sram [4096];

  mem_port_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .req           (req),
    .we            (we),
    .lock          (lock),
    .addr          (addr),
    .wdata         (wdata),
    .gnt           (gnt),
    .rvalid        (rvalid),
    .rdata         (rdata),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .perf_clear    (perf_clear),
    .perf_grants   (perf_grants),
    .perf_conflict (perf_conflict)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous SRAM: read data one cycle after a read enable.
  always @(posedge clock) begin
    if (mem_en && mem_addr[19:12] == 8'h00) begin
      if (mem_we) sram[mem_addr[11:0]] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr[11:0]];
    end
  end

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  we;
    logic [2:0]  lock;
    logic [19:0] a1;
    logic [2:0]  gnt;
    logic [2:0]  rv;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt [18];

  function automatic vec_t mk(input logic [2:0] r, input logic [2:0] w, input logic [2:0] l,
                              input logic [19:0] a, input logic [2:0] g, input logic [2:0] v,
                              input logic [31:0] d);
    vec_t x;
    x.req = r; x.we = w; x.lock = l; x.a1 = a; x.gnt = g; x.rv = v; x.rdata = d;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_vecs(input int lo, input int hi);
    logic [19:0] ea;
    logic [31:0] ed;
    for (int n = lo; n <= hi; n++) begin
      @(negedge clock);
      req   = vt[n].req;
      we    = vt[n].we;
      lock  = vt[n].lock;
      addr  = {20'h00010, vt[n].a1, 20'h00200};
      wdata = {32'hC0C0C0C0, 32'hA0000000 | {12'h000, vt[n].a1}, 32'h0A0A0A0A};
      #1;
      case (vt[n].gnt)
        3'b001:  begin ea = 20'h00200;  ed = 32'h0A0A0A0A; end
        3'b010:  begin ea = vt[n].a1;   ed = 32'hA0000000 | {12'h000, vt[n].a1}; end
        3'b100:  begin ea = 20'h00010;  ed = 32'hC0C0C0C0; end
        default: begin ea = 20'h00000;  ed = 32'h00000000; end
      endcase
      chk($sformatf("gnt[%0d]", n),       64'(gnt),       64'(vt[n].gnt));
      chk($sformatf("rvalid[%0d]", n),    64'(rvalid),    64'(vt[n].rv));
      if (vt[n].rv != 3'b000)
        chk($sformatf("rdata[%0d]", n),   64'(rdata),     64'(vt[n].rdata));
      chk($sformatf("mem_en[%0d]", n),    64'(mem_en),    64'(|vt[n].gnt));
      chk($sformatf("mem_we[%0d]", n),    64'(mem_we),    64'(|(vt[n].gnt & vt[n].we)));
      chk($sformatf("mem_addr[%0d]", n),  64'(mem_addr),  64'(ea));
      chk($sformatf("mem_wdata[%0d]", n), 64'(mem_wdata), 64'(ed));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_g, exp_c;
`ifdef MEM_ARB_PERF_EN
    exp_g = 32'd6;  exp_c = 32'd12;
`else
    exp_g = 32'd0;  exp_c = 32'd0;
`endif
    for (int i = 0; i < 4096; i++) sram[i] = 32'h0;
    sram[12'h010] = 32'h00000013;
    mem_rdata = '0;

    // req       we      lock    a1         gnt     rvalid  rdata
    vt[0]  = mk(3'b111, 3'b000, 3'b000, 20'h00300, 3'b001, 3'b000, 32'h0);
    vt[1]  = mk(3'b111, 3'b000, 3'b000, 20'h00300, 3'b010, 3'b001, 32'h0);
    vt[2]  = mk(3'b111, 3'b000, 3'b000, 20'h00300, 3'b100, 3'b010, 32'h0);
    vt[3]  = mk(3'b111, 3'b000, 3'b000, 20'h00300, 3'b001, 3'b100, 32'h13);
    vt[4]  = mk(3'b111, 3'b000, 3'b000, 20'h00300, 3'b010, 3'b001, 32'h0);
    vt[5]  = mk(3'b111, 3'b000, 3'b000, 20'h00300, 3'b100, 3'b010, 32'h0);
    vt[6]  = mk(3'b000, 3'b000, 3'b000, 20'h00300, 3'b000, 3'b100, 32'h13);
    vt[7]  = mk(3'b100, 3'b000, 3'b000, 20'h00300, 3'b100, 3'b000, 32'h0);
    vt[8]  = mk(3'b000, 3'b000, 3'b000, 20'h00300, 3'b000, 3'b100, 32'h13);
    vt[9]  = mk(3'b110, 3'b010, 3'b010, 20'h00100, 3'b010, 3'b000, 32'h0);
    vt[10] = mk(3'b110, 3'b010, 3'b010, 20'h00101, 3'b010, 3'b000, 32'h0);
    vt[11] = mk(3'b110, 3'b010, 3'b000, 20'h00102, 3'b010, 3'b000, 32'h0);
    vt[12] = mk(3'b100, 3'b000, 3'b000, 20'h00300, 3'b100, 3'b000, 32'h0);
    vt[13] = mk(3'b000, 3'b000, 3'b000, 20'h00300, 3'b000, 3'b100, 32'h13);
    vt[14] = mk(3'b001, 3'b000, 3'b001, 20'h00300, 3'b001, 3'b000, 32'h0);
    vt[15] = mk(3'b110, 3'b000, 3'b000, 20'h00101, 3'b000, 3'b001, 32'h0);
    vt[16] = mk(3'b110, 3'b000, 3'b000, 20'h00101, 3'b010, 3'b000, 32'h0);
    vt[17] = mk(3'b000, 3'b000, 3'b000, 20'h00101, 3'b000, 3'b010, 32'hA0000101);

    reset = 1'b1; req = 3'b111; we = 3'b000; lock = 3'b000; perf_clear = 1'b0;
    addr = '0; wdata = '0;
    #2;
    chk("reset_gnt",    64'(gnt),    64'(3'b000));
    chk("reset_mem_en", 64'(mem_en), 64'(1'b0));
    chk("reset_rvalid", 64'(rvalid), 64'(3'b000));
    repeat (2) @(posedge clock);
    #1;
    chk("reset_gnt_hold", 64'(gnt),    64'(3'b000));
    chk("reset_perf_g",   64'(perf_grants), 64'(32'd0));
    @(negedge clock);
    reset = 1'b0; req = 3'b000;

    run_vecs(0, 5);
    @(posedge clock);
    #1;
    chk("perf_grants_rr",   64'(perf_grants),   64'(exp_g));
    chk("perf_conflict_rr", 64'(perf_conflict), 64'(exp_c));
    run_vecs(6, 17);

    chk("sram_100", 64'(sram[12'h100]), 64'(32'hA0000100));
    chk("sram_101", 64'(sram[12'h101]), 64'(32'hA0000101));
    chk("sram_102", 64'(sram[12'h102]), 64'(32'hA0000102));

    // Asynchronous reset lands inside the grant cycle of a read.
    @(negedge clock);
    req = 3'b010; we = 3'b000; lock = 3'b000;
    #1;
    chk("rd_before_rst_gnt", 64'(gnt), 64'(3'b010));
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_gnt",    64'(gnt),    64'(3'b000));
    chk("rst_async_mem_en", 64'(mem_en), 64'(1'b0));
    @(posedge clock);
    #1;
    chk("rst_drop_rvalid", 64'(rvalid), 64'(3'b000));
    @(negedge clock);
    reset = 1'b0; req = 3'b111;
    #1;
    chk("rst_rrptr_gnt", 64'(gnt), 64'(3'b001));
    @(posedge clock);
    #1;
    chk("post_rst_rvalid", 64'(rvalid), 64'(3'b001));

    // Clear wins over same-cycle increments.
    @(negedge clock);
    perf_clear = 1'b1;
    @(posedge clock);
    #1;
    chk("perf_clear_g", 64'(perf_grants),   64'(32'd0));
    chk("perf_clear_c", 64'(perf_conflict), 64'(32'd0));
    @(negedge clock);
    perf_clear = 1'b0; req = 3'b000;
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
